word_fifo: RTL and testbench

WORD_FIFO -- requirements
Module: word_fifo

---
 rtl/word_fifo.sv | 73 +++++++
 tb/tb_word_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/word_fifo.sv
// word_fifo: show-ahead synchronous FIFO with valid/ready handshakes on both sides.
// Storage is a DEPTH-entry register array; DataOut always shows the oldest word.
// Optional occupancy port Level is compiled in when WORD_FIFO_LEVEL_EN is defined.
// DEPTH must be a power of two (2..64) so the pointers wrap naturally.

module word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_Valid,
  output logic                       in_Ready,
  input  logic [WIDTH-1:0]           DataIn,
  output logic                       out_Valid,
  input  logic                       out_Ready,
  output logic [WIDTH-1:0]           DataOut
`ifdef WORD_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] Level
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  // Handshake flags depend only on registered occupancy, never on the requests.
  always_comb begin
    in_Ready  = (count_q != CW'(DEPTH));
    out_Valid = (count_q != '0);
    push      = in_Valid && in_Ready;
    pop       = out_Valid && out_Ready;
    DataOut   = mem[rd_ptr_q];
  end

  // Pointer and occupancy state; reset clears them immediately, discarding stored words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: plain increment wraps DEPTH-1 -> 0.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= DataIn;
  end

`ifdef WORD_FIFO_LEVEL_EN
  // Occupancy export; widths match for power-of-two DEPTH.
  always_comb begin
    Level = ($clog2(DEPTH+1))'(count_q);
  end
`endif

endmodule

// File: tb/tb_word_fifo.sv
// tb_word_fifo: directed handshake scenarios plus randomized traffic, checked by a
// queue-based reference model (occupancy as an integer, data as an ordered queue).
// Level checks are included only when WORD_FIFO_LEVEL_EN is defined.

module tb_word_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_Valid;
  logic             in_Ready;
  logic [WIDTH-1:0] DataIn;
  logic             out_Valid;
  logic             out_Ready;
  logic [WIDTH-1:0] DataOut;
`ifdef WORD_FIFO_LEVEL_EN
  logic [LW-1:0]    Level;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] exp_q [$];
  int               model_cnt = 0;
  bit               accepted  = 1'b0;

  word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_Valid (in_Valid),
    .in_Ready (in_Ready),
    .DataIn   (DataIn),
    .out_Valid(out_Valid),
    .out_Ready(out_Ready),
    .DataOut  (DataOut)
`ifdef WORD_FIFO_LEVEL_EN
    ,
    .Level    (Level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_level(input string name, input int exp);
`ifdef WORD_FIFO_LEVEL_EN
    check(name, 64'(Level), 64'(exp));
`else
    check(name, 64'(in_Ready), 64'(exp != DEPTH));
`endif
  endtask

  // Model: flags from occupancy, push accepted only below DEPTH, pop only above 0.
  always @(negedge clk) begin
    int push_ok;
    int pop_ok;
    if (rst) begin
      model_cnt = 0;
      exp_q.delete();
      accepted  = 1'b0;
    end
    check("in_ready", 64'(in_Ready), 64'(model_cnt != DEPTH));
    check("out_valid", 64'(out_Valid), 64'(model_cnt != 0));
`ifdef WORD_FIFO_LEVEL_EN
    check("level", 64'(Level), 64'(model_cnt));
`endif
    if (!rst) begin
      push_ok = (in_Valid && model_cnt < DEPTH) ? 1 : 0;
      pop_ok  = (out_Ready && model_cnt > 0) ? 1 : 0;
      if (push_ok == 1) exp_q.push_back(DataIn);
      model_cnt = model_cnt + push_ok - pop_ok;
      accepted  = in_Valid && in_Ready;
    end
  end

  // Monitor: every word the DUT hands over must be the oldest expected word.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp;
    if (!rst && out_Valid && out_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected no word at %0t", DataOut, $time);
      end else begin
        exp = exp_q.pop_front();
        check("data_out", 64'(DataOut), 64'(exp));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_Valid  = 1'b0;
    out_Ready = 1'b1;
    while (out_Valid && n < 64) begin
      cyc();
      n++;
    end
    check("drain_done", 64'(out_Valid), 64'(0));
    check("drain_queue", 64'(exp_q.size()), 64'(0));
    out_Ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_Valid  = 1'b0;
    out_Ready = 1'b0;
    DataIn    = '0;
    #1;
    check("reset_in_ready", 64'(in_Ready), 64'(1));
    check("reset_out_valid", 64'(out_Valid), 64'(0));
    check_level("reset_level", 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word into empty FIFO
    in_Valid  = 1'b1;
    DataIn    = 32'hFFFF_0000;
    out_Ready = 1'b0;
    cyc();
    in_Valid = 1'b0;
    check("one_out_valid", 64'(out_Valid), 64'(1));
    check("one_data", 64'(DataOut), 64'(32'hFFFF_0000));
    check("one_in_ready", 64'(in_Ready), 64'(1));
    check_level("one_level", 1);
    cyc();
    check("one_held", 64'(DataOut), 64'(32'hFFFF_0000));
    drain();

    // Fill to full, 9th word refused
    for (int i = 1; i <= 8; i++) begin
      in_Valid = 1'b1;
      DataIn   = WIDTH'(i);
      cyc();
    end
    check("full_in_ready", 64'(in_Ready), 64'(0));
    check_level("full_level", 8);
    DataIn = 32'h9;
    cyc();
    check_level("full_refused", 8);
    check("full_head", 64'(DataOut), 64'(1));

    // Pop once while full with 0x9 held: refused that edge, accepted the next
    out_Ready = 1'b1;
    cyc();
    out_Ready = 1'b0;
    check("after_pop_in_ready", 64'(in_Ready), 64'(1));
    check_level("after_pop_level", 7);
    cyc();
    in_Valid = 1'b0;
    check_level("refill_level", 8);
    check("refill_in_ready", 64'(in_Ready), 64'(0));
    drain();

    // Streaming through pointer wrap
    in_Valid  = 1'b1;
    out_Ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DataIn = $urandom;
      cyc();
      check_level("stream_level", 1);
      check("stream_out_valid", 64'(out_Valid), 64'(1));
    end
    in_Valid = 1'b0;
    drain();

    // Asynchronous reset between edges at Level 5
    for (int i = 0; i < 5; i++) begin
      in_Valid = 1'b1;
      DataIn   = 32'hC000_0000 + WIDTH'(i);
      cyc();
    end
    in_Valid = 1'b0;
    check_level("pre_reset_level", 5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_out_valid", 64'(out_Valid), 64'(0));
    check("async_in_ready", 64'(in_Ready), 64'(1));
    check_level("async_level", 0);
    @(posedge clk);
    #1 rst = 1'b0;
    in_Valid = 1'b1;
    DataIn   = 32'h5A5A_C3C3;
    cyc();
    in_Valid = 1'b0;
    check("post_reset_valid", 64'(out_Valid), 64'(1));
    check("post_reset_data", 64'(DataOut), 64'(32'h5A5A_C3C3));
    drain();

    // Randomized traffic in three back-pressure regimes; producer holds refused words
    for (int phase = 0; phase < 3; phase++) begin
      int rdy_pct;
      rdy_pct = (phase == 0) ? 20 : ((phase == 1) ? 50 : 85);
      for (int i = 0; i < 600; i++) begin
        if (!(in_Valid && !accepted)) begin
          in_Valid = ($urandom_range(0, 99) < 60);
          DataIn   = $urandom;
        end
        out_Ready = ($urandom_range(0, 99) < rdy_pct);
        cyc();
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
